// File: rtl/dcache_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl_m
//  Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//             controller. It sits between the ALU address path and a slow
//             backing data memory. Read hits answer in one cycle. Read misses
//             and all stores go out on a req/ack memory handshake, and the
//             processor is stalled while they are outstanding.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   rising-edge clock
//    reset       in   asynchronous active-high reset
//    MemRead     in   load request (sampled in IDLE only)
//    MemWrite    in   store request (sampled in IDLE only, wins over MemRead)
//    addr        in   byte address; bits [1:0] are ignored
//    write_data  in   store data
//    read_data   out  load result, valid while done=1
//    stall       out  registered hold for PC and request
//    done        out  one-cycle completion pulse
//    mem_req     out  backing-memory request, held until mem_ack
//    mem_we      out  1 = write, 0 = read
//    mem_addr    out  word-aligned memory address
//    mem_wdata   out  memory write data
//    mem_rdata   in   fill data, valid with mem_ack
//    mem_ack     in   single-cycle acknowledge
//    hit_count   out  saturating read-hit counter
//    miss_count  out  saturating read-miss counter
// ============================================================================
module dcache_ctrl_m #(
    parameter int LINES = 16,   // power of two, at least 2
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] write_data,
    output logic [DW-1:0] read_data,
    output logic          stall,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = DW - IW - 2;

    localparam logic [DW-1:0] c_WORD_MASK = {{(DW-2){1'b1}}, 2'b00};
    localparam logic [15:0]   c_CNT_MAX   = 16'hFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESP  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]       r_state;
    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [DW-1:0]    r_data [LINES];

    // Request-side lookup
    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic          w_hit;
    logic [DW-1:0] w_aligned;

    // The fill uses the latched miss address, not the live request address
    logic [IW-1:0] w_fill_idx;
    logic [TW-1:0] w_fill_tag;

    // Single write port into the tag/data arrays
    logic          w_arr_we;
    logic [IW-1:0] w_arr_idx;
    logic [TW-1:0] w_arr_tag;
    logic [DW-1:0] w_arr_data;

    assign w_idx      = addr[IW+1:2];
    assign w_tag      = addr[DW-1:IW+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_aligned  = addr & c_WORD_MASK;

    assign w_fill_idx = mem_addr[IW+1:2];
    assign w_fill_tag = mem_addr[DW-1:IW+2];

    assign done = (r_state == S_RESP);

    // A store that hits updates the word in the same cycle the write-through
    // request is issued. A store that misses leaves the arrays untouched, so
    // no line is allocated. That includes a store to a non-resident alias.
    always_comb begin
        w_arr_we   = 1'b0;
        w_arr_idx  = w_idx;
        w_arr_tag  = w_tag;
        w_arr_data = write_data;
        if (r_state == S_IDLE && MemWrite && w_hit) begin
            w_arr_we = 1'b1;
        end else if (r_state == S_FILL && mem_ack) begin
            w_arr_we   = 1'b1;
            w_arr_idx  = w_fill_idx;
            w_arr_tag  = w_fill_tag;
            w_arr_data = mem_rdata;
        end
    end

    // The tag/data arrays have no reset. Only the valid bits qualify them.
    always_ff @(posedge clock) begin
        if (w_arr_we) begin
            r_tag[w_arr_idx]  <= w_arr_tag;
            r_data[w_arr_idx] <= w_arr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            read_data  <= '0;
            stall      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MemWrite) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= w_aligned;
                        mem_wdata <= write_data;
                        stall     <= 1'b1;
                        r_state   <= S_WRITE;
                    end else if (MemRead) begin
                        if (w_hit) begin
                            read_data <= r_data[w_idx];
                            r_state   <= S_RESP;
                            if (hit_count != c_CNT_MAX) begin
                                hit_count <= hit_count + 16'd1;
                            end
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= w_aligned;
                            stall    <= 1'b1;
                            r_state  <= S_FILL;
                            if (miss_count != c_CNT_MAX) begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    // Requests still held by the processor are re-sampled in IDLE.
                    r_state <= S_IDLE;
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        read_data           <= mem_rdata;
                        mem_req             <= 1'b0;
                        stall               <= 1'b0;
                        r_state             <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        stall   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl_m
//  Purpose  : Directed self-checking bench for dcache_ctrl_m. The expected
//             read_data of each access is queued when the access is driven
//             and popped when done pulses. Counters are checked against
//             bench-side tallies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl_m;

    logic        clock;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int          checks;
    int          failures;
    int          exp_hit;
    int          exp_miss;
    logic [31:0] last_rd;
    logic [31:0] sb [$];

    dcache_ctrl_m #(.LINES(16), .DW(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".hit_count"},  {16'd0, hit_count},  32'(exp_hit));
        chk({tag, ".miss_count"}, {16'd0, miss_count}, 32'(exp_miss));
    endtask

    // Called in the cycle the access should complete.
    task automatic expect_resp(input string tag);
        logic [31:0] e;
        chk({tag, ".done"},  {31'd0, done},  32'd1);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".read_data"}, read_data, e);
            last_rd = e;
        end
        step();
        chk({tag, ".done_low"}, {31'd0, done}, 32'd0);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
        step();
        step();
        reset    = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        last_rd  = '0;
        sb.delete();
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input bit miss, input int delay,
                           input logic [31:0] fdata, input logic [31:0] exp,
                           input string tag);
        MemRead = 1'b1;
        addr    = a;
        sb.push_back(exp);
        step();
        MemRead = 1'b0;
        if (miss) begin
            exp_miss++;
            chk({tag, ".stall"},    {31'd0, stall},   32'd1);
            chk({tag, ".mem_req"},  {31'd0, mem_req}, 32'd1);
            chk({tag, ".mem_we"},   {31'd0, mem_we},  32'd0);
            chk({tag, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
            for (int i = 0; i < delay; i++) begin
                step();
                chk({tag, ".mem_req_held"},  {31'd0, mem_req}, 32'd1);
                chk({tag, ".mem_addr_held"}, mem_addr, a & 32'hFFFF_FFFC);
            end
            mem_ack   = 1'b1;
            mem_rdata = fdata;
            step();
            mem_ack   = 1'b0;
            mem_rdata = '0;
            chk({tag, ".mem_req_drop"}, {31'd0, mem_req}, 32'd0);
        end else begin
            exp_hit++;
            chk({tag, ".no_mem_req"}, {31'd0, mem_req}, 32'd0);
        end
        expect_resp(tag);
        chk_counters(tag);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_read,
                            input int delay, input string tag);
        MemWrite   = 1'b1;
        MemRead    = with_read;
        addr       = a;
        write_data = d;
        sb.push_back(last_rd);
        step();
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        chk({tag, ".stall"},     {31'd0, stall},   32'd1);
        chk({tag, ".mem_req"},   {31'd0, mem_req}, 32'd1);
        chk({tag, ".mem_we"},    {31'd0, mem_we},  32'd1);
        chk({tag, ".mem_addr"},  mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".mem_wdata"}, mem_wdata, d);
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, ".mem_req_held"},   {31'd0, mem_req}, 32'd1);
            chk({tag, ".mem_wdata_held"}, mem_wdata, d);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        expect_resp(tag);
        chk_counters(tag);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_hit    = 0;
        exp_miss   = 0;
        last_rd    = '0;
        reset      = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        addr       = '0;
        write_data = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;

        // Check the reset state while reset is still asserted.
        step();
        step();
        chk("rst.read_data", read_data, 32'd0);
        chk("rst.stall",     {31'd0, stall},   32'd0);
        chk("rst.done",      {31'd0, done},    32'd0);
        chk("rst.mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst.mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst.mem_addr",  mem_addr,  32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk_counters("rst");
        reset = 1'b0;
        step();

        // Read miss then hit
        do_read(32'h40, 1'b1, 3, 32'hDEADBEEF, 32'hDEADBEEF, "rd_miss_40");
        do_read(32'h40, 1'b0, 0, 32'h0,        32'hDEADBEEF, "rd_hit_40");

        // Write-through hit, then read back the updated word
        do_write(32'h40, 32'h12345678, 1'b0, 2, "wr_hit_40");
        do_read(32'h43, 1'b0, 0, 32'h0, 32'h12345678, "rd_after_wr_40");

        // Store to an alias of the resident line, acknowledged in the first
        // request cycle; no allocation, so the following read misses.
        do_write(32'h80, 32'hAAAA5555, 1'b0, 0, "wr_miss_80");
        do_read(32'h80, 1'b1, 1, 32'h80808080, 32'h80808080, "rd_miss_80");

        // Conflict eviction from a fresh cache
        apply_reset();
        do_read(32'h40,  1'b1, 1, 32'h0000000A, 32'h0000000A, "evict_rd_40");
        do_read(32'h440, 1'b1, 2, 32'h0000000B, 32'h0000000B, "evict_rd_440");
        do_read(32'h40,  1'b1, 0, 32'h0000000A, 32'h0000000A, "evict_rd_40_again");
        // A store to the non-resident alias must leave the resident line alone.
        do_write(32'h440, 32'h000000CC, 1'b0, 1, "wr_alias_440");
        do_read(32'h40,  1'b0, 0, 32'h0, 32'h0000000A, "rd_hit_40_after_alias");

        // MemRead and MemWrite together are handled as a store.
        do_write(32'h10, 32'h5A5A0001, 1'b1, 1, "rd_wr_both_10");

        // Reset two cycles into a miss abandons the fill.
        MemRead = 1'b1;
        addr    = 32'h200;
        step();
        MemRead = 1'b0;
        chk("rstfill.mem_req_up", {31'd0, mem_req}, 32'd1);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rstfill.mem_req",    {31'd0, mem_req},    32'd0);
        chk("rstfill.stall",      {31'd0, stall},      32'd0);
        chk("rstfill.hit_count",  {16'd0, hit_count},  32'd0);
        chk("rstfill.miss_count", {16'd0, miss_count}, 32'd0);
        step();
        reset    = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        last_rd  = '0;
        step();
        do_read(32'h200, 1'b1, 2, 32'h0BADF00D, 32'h0BADF00D, "rstfill.rd_200");
        // 0x40 was resident before the reset, but every line is now invalid.
        do_read(32'h40,  1'b1, 0, 32'h00000041, 32'h00000041, "rstfill.rd_40");

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl_m.md
Name: dcache_ctrl_m

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the ALU/address path and a slow backing data memory.
- Sits where the datacache_m array is accessed. Takes MemRead/MemWrite plus the ALU result as the address, and returns read data toward the MemtoReg mux.
- Holds the processor with stall while a miss fill or a write-through is outstanding on a req/ack memory handshake.

Parameters:
- LINES, 16, number of one-word cache lines; power of two; index width IW = log2(LINES).
- DW, 32, data and address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- MemRead  in  1  load request, sampled only when stall=0
- MemWrite  in  1  store request, sampled only when stall=0
- addr  in  DW  byte address (ALU_Result); addr[1:0] ignored
- write_data  in  DW  store data (Read_data2)
- read_data  out  DW  load result, valid when done=1
- stall  out  1  processor must hold PC and the request while high
- done  out  1  one-cycle pulse when the accepted access completes
- mem_req  out  1  backing-memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1
- mem_addr  out  DW  word-aligned address; stable while mem_req=1
- mem_wdata  out  DW  write data; stable while mem_req=1
- mem_rdata  in  DW  fill data, valid in the mem_ack cycle
- mem_ack  in  1  single-cycle acknowledge
- hit_count  out  16  saturating count of read hits
- miss_count  out  16  saturating count of read misses

Behaviour:
- Address split:
  - index = addr[IW+1:2]
  - tag = addr[DW-1:IW+2]
  - per line: valid bit, tag, data word.
- Reset (async):
  - all valid bits cleared
  - state=IDLE
  - read_data=0, stall=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - hit_count=0, miss_count=0
  - Tag/data arrays need no reset.
- FSM states: IDLE, RESP, FILL, WRITE.
- IDLE:
  - MemWrite=1 (has priority if MemRead is also 1) -> latch addr/write_data; next WRITE; stall=1 from the next cycle.
  - MemRead=1 and hit (valid && tag match) -> read_data <= line data; next RESP; hit_count++.
  - MemRead=1 and miss -> mem_req=1, mem_we=0, mem_addr={addr[DW-1:2],2'b00}; next FILL; miss_count++.
  - Neither -> stay IDLE; done=0.
- RESP: done=1 for one cycle, stall=0; next IDLE. Read-hit latency is 1 cycle (done in the cycle after the request).
- FILL:
  - stall=1; hold mem_* until mem_ack.
  - On mem_ack: write line (valid=1, tag, mem_rdata); read_data <= mem_rdata; mem_req <= 0; next RESP.
- WRITE:
  - stall=1; mem_req=1, mem_we=1, with latched address and data.
  - Update: if the line hits, update the data word in the same cycle the request is issued. On a miss, do not allocate.
  - On mem_ack: mem_req <= 0; next RESP (done pulses; read_data unchanged).
- stall:
  - Registered.
  - High every cycle the FSM is in FILL or WRITE, and in the first cycle after a miss or write is accepted.
  - Low in IDLE and RESP.
- Requests arriving while stall=1 are ignored. The processor holds them, so they are re-sampled in IDLE after RESP.
- mem_ack in IDLE or RESP is ignored.
- mem_ack in the same cycle mem_req first rises is legal and completes the transaction.
- Counters saturate at 16'hFFFF with no wrap. Write hits and write misses are not counted.
- Reset asserted mid-FILL or mid-WRITE:
  - immediately drops mem_req
  - invalidates all lines
  - returns to IDLE
  - The outstanding transaction is abandoned.
- Aliasing: two addresses with the same index and different tags evict each other on read fill. A write to a non-resident alias leaves the resident line untouched.

Test Plan:
- Read miss then hit: reset; MemRead addr=0x40; mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_req=1 with mem_addr=0x40 and mem_we=0 until ack; done and read_data=0xDEADBEEF one cycle after ack; miss_count=1. Repeat the read -> done 1 cycle later with no mem_req; hit_count=1.
- Write-through hit: after the previous test, MemWrite addr=0x40 data=0x12345678 -> mem_req=1, mem_we=1, mem_wdata=0x12345678 until ack. Following read of 0x40 hits and returns 0x12345678.
- Write no-allocate: MemWrite addr=0x80 on an empty cache -> memory write issued. Read 0x80 then misses (miss_count increments).
- Conflict eviction (LINES=16): read 0x40 (fill 0xA), read 0x440 (fill 0xB), read 0x40 -> third access misses and returns 0xA; miss_count=3.
- Simultaneous MemRead=MemWrite=1 at addr 0x10 -> treated as a write (mem_we=1); hit_count and miss_count unchanged.
- Reset during FILL: assert reset two cycles into a miss -> mem_req=0, stall=0, and counters=0 immediately. A subsequent read of the same address misses.
